// File: rtl/door_pkg.sv
// Shared definitions for the door plant model: state encoding and the
// default values of the plant parameters.
package door_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_UP    = 2'd1,
        S_DN    = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int TRAVEL_DEF    = 8;
    localparam int STEP_DIV_DEF  = 2;
    localparam int STALL_MAX_DEF = 4;

endpackage

// File: rtl/door_step_gen.sv
// Movement prescaler: counts 0..STEP_DIV-1 while the door is moving and
// raises a one-cycle step strobe on the last count. A clear (state change)
// zeroes the count and suppresses the strobe, so a partial step is lost.
module door_step_gen
    import door_pkg::*;
#(
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic step
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    assign step = run && !clear && (cnt == LAST);

    // Prescaler count: only advances while running and not being cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !run || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/door_plant.sv
// Behavioural plant model of a motorised door: position integrates the
// motor commands, endstop limits are reported, and driving into an endstop
// for too long or commanding both directions at once latches a fault.
module door_plant
    import door_pkg::*;
#(
    parameter int TRAVEL    = TRAVEL_DEF,
    parameter int STEP_DIV  = STEP_DIV_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          motor_up,
    input  logic                          motor_dn,
    input  logic                          clr_fault,
    output logic                          up_limit,
    output logic                          dn_limit,
    output logic [$clog2(TRAVEL+1)-1:0]   pos,
    output logic                          moving,
    output logic                          fault
);

    localparam int PW = $clog2(TRAVEL + 1);
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [PW-1:0] POS_TOP   = PW'(TRAVEL);
    localparam logic [SW-1:0] STALL_END = SW'(STALL_MAX - 1);

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] pos_next;
    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] stall_next;
    logic          stalled;
    logic          run;
    logic          change;
    logic          step;

    assign run     = (state == S_UP) || (state == S_DN);
    assign change  = (state_next != state);
    assign stalled = ((state == S_UP) && (pos == POS_TOP)) ||
                     ((state == S_DN) && (pos == '0));

    door_step_gen #(.STEP_DIV(STEP_DIV)) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .clear (change),
        .step  (step)
    );

    // Next state, next position and next stall count.
    always_comb begin
        state_next = state;
        pos_next   = pos;
        stall_next = '0;

        unique case (state)
            S_IDLE: begin
                if (motor_up && !motor_dn) begin
                    state_next = S_UP;
                end else if (motor_dn && !motor_up) begin
                    state_next = S_DN;
                end
            end
            S_UP: begin
                if (!(motor_up && !motor_dn)) begin
                    state_next = S_IDLE;
                end else if (stalled && (stall_cnt == STALL_END)) begin
                    state_next = S_FAULT;
                end
            end
            S_DN: begin
                if (!(motor_dn && !motor_up)) begin
                    state_next = S_IDLE;
                end else if (stalled && (stall_cnt == STALL_END)) begin
                    state_next = S_FAULT;
                end
            end
            S_FAULT: begin
                if (clr_fault && !motor_up && !motor_dn) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Conflicting commands override every other transition.
        if (motor_up && motor_dn && (state != S_FAULT)) begin
            state_next = S_FAULT;
        end

        if (step) begin
            if ((state == S_UP) && (pos != POS_TOP)) begin
                pos_next = pos + 1'b1;
            end else if ((state == S_DN) && (pos != '0)) begin
                pos_next = pos - 1'b1;
            end
        end

        if (stalled && !change) begin
            stall_next = stall_cnt + 1'b1;
        end
    end

    // State, position and all outputs are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pos       <= POS_TOP;
            stall_cnt <= '0;
            up_limit  <= 1'b1;
            dn_limit  <= 1'b0;
            moving    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_next;
            pos       <= pos_next;
            stall_cnt <= stall_next;
            up_limit  <= (pos_next == POS_TOP);
            dn_limit  <= (pos_next == '0);
            moving    <= (state_next == S_UP) || (state_next == S_DN);
            fault     <= (state_next == S_FAULT);
        end
    end

endmodule

// File: tb/tb_door_plant.sv
// Testbench for door_plant with TRAVEL=8, STEP_DIV=2, STALL_MAX=4.
module tb_door_plant;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       motor_up = 1'b0;
    logic       motor_dn = 1'b0;
    logic       clr_fault = 1'b0;
    logic       up_limit;
    logic       dn_limit;
    logic [3:0] pos;
    logic       moving;
    logic       fault;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       up;
        logic       dn;
        logic       clr;
        logic [3:0] pos;
        logic       ul;
        logic       dl;
        logic       mv;
        logic       flt;
        string      nm;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        string      nm;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];

    door_plant #(.TRAVEL(8), .STEP_DIV(2), .STALL_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .motor_up  (motor_up),
        .motor_dn  (motor_dn),
        .clr_fault (clr_fault),
        .up_limit  (up_limit),
        .dn_limit  (dn_limit),
        .pos       (pos),
        .moving    (moving),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic u, input logic d, input logic c,
                                input logic [3:0] p, input logic ul, input logic dl,
                                input logic mv, input logic f, input string nm);
        vec_t v;
        v.up = u; v.dn = d; v.clr = c;
        v.pos = p; v.ul = ul; v.dl = dl; v.mv = mv; v.flt = f; v.nm = nm;
        return v;
    endfunction

    task automatic check_now(input string nm, input logic [7:0] exp);
        logic [7:0] got;
        got = {pos, up_limit, dn_limit, moving, fault};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got pos=%0d ul=%b dl=%b mv=%b flt=%b, want pos=%0d ul=%b dl=%b mv=%b flt=%b",
                     nm, got[7:4], got[3], got[2], got[1], got[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        sb_t e;
        motor_up  = v.up;
        motor_dn  = v.dn;
        clr_fault = v.clr;
        e.exp = {v.pos, v.ul, v.dl, v.mv, v.flt};
        e.nm  = v.nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_now(e.nm, e.exp);
        @(negedge clk);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] p;

        // Reset held across edges.
        repeat (2) @(posedge clk);
        #1;
        check_now("reset", {4'd8, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // Table: idle, stall driving up at the top, fault handling.
        tbl.push_back(mk(0,0,0, 8,1,0,0,0, "idle"));
        tbl.push_back(mk(1,0,0, 8,1,0,1,0, "up_start_top"));
        tbl.push_back(mk(1,0,0, 8,1,0,1,0, "up_stall1"));
        tbl.push_back(mk(1,0,0, 8,1,0,1,0, "up_stall2"));
        tbl.push_back(mk(1,0,0, 8,1,0,1,0, "up_stall3"));
        tbl.push_back(mk(1,0,0, 8,1,0,0,1, "up_stall_fault"));
        tbl.push_back(mk(1,0,1, 8,1,0,0,1, "clr_with_up"));
        tbl.push_back(mk(0,0,0, 8,1,0,0,1, "fault_hold"));
        tbl.push_back(mk(0,0,1, 8,1,0,0,0, "clr_ok"));
        foreach (tbl[i]) apply(tbl[i]);

        // Full lowering from the top.
        apply(mk(0,1,0, 8,1,0,1,0, "dn_start"));
        for (int i = 1; i <= 16; i++) begin
            p = 4'(8 - i / 2);
            apply(mk(0,1,0, p, p == 4'd8, p == 4'd0, 1, 0, "lower"));
        end
        apply(mk(0,1,0, 0,0,1,1,0, "bottom_hold1"));
        apply(mk(0,1,0, 0,0,1,1,0, "bottom_hold2"));
        apply(mk(0,0,0, 0,0,1,0,0, "dn_release"));
        apply(mk(0,0,0, 0,0,1,0,0, "idle_bottom"));

        // Stall at the bottom endstop.
        apply(mk(0,1,0, 0,0,1,1,0, "stall_start"));
        apply(mk(0,1,0, 0,0,1,1,0, "stall_c1"));
        apply(mk(0,1,0, 0,0,1,1,0, "stall_c2"));
        apply(mk(0,1,0, 0,0,1,1,0, "stall_c3"));
        apply(mk(0,1,0, 0,0,1,0,1, "stall_fault"));
        apply(mk(0,0,1, 0,0,1,0,0, "stall_clr"));

        // Raise to 5, then conflicting commands.
        apply(mk(1,0,0, 0,0,1,1,0, "up_start"));
        for (int j = 1; j <= 10; j++) begin
            p = 4'(j / 2);
            apply(mk(1,0,0, p, 0, p == 4'd0, 1, 0, "raise"));
        end
        apply(mk(1,1,0, 5,0,0,0,1, "illegal"));
        apply(mk(1,0,1, 5,0,0,0,1, "illegal_clr_up"));
        apply(mk(0,0,1, 5,0,0,0,0, "illegal_clr_ok"));

        // Reversal: down to 4, then up.
        apply(mk(0,1,0, 5,0,0,1,0, "rev_dn_start"));
        apply(mk(0,1,0, 5,0,0,1,0, "rev_dn_c1"));
        apply(mk(0,1,0, 4,0,0,1,0, "rev_dn_c2"));
        apply(mk(1,0,0, 4,0,0,0,0, "rev_idle"));
        apply(mk(1,0,0, 4,0,0,1,0, "rev_up_start"));
        apply(mk(1,0,0, 4,0,0,1,0, "rev_up_c1"));
        apply(mk(1,0,0, 5,0,0,1,0, "rev_up_c2"));

        // Reverse again and lower to 3, then reset mid-travel.
        apply(mk(0,1,0, 5,0,0,0,0, "rev2_idle"));
        apply(mk(0,1,0, 5,0,0,1,0, "rev2_dn_start"));
        apply(mk(0,1,0, 5,0,0,1,0, "rev2_c1"));
        apply(mk(0,1,0, 4,0,0,1,0, "rev2_c2"));
        apply(mk(0,1,0, 4,0,0,1,0, "rev2_c3"));
        apply(mk(0,1,0, 3,0,0,1,0, "rev2_c4"));
        rst_n = 1'b0;
        #1;
        check_now("async_reset", {4'd8, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        motor_dn = 1'b0;
        rst_n = 1'b1;
        apply(mk(0,0,0, 8,1,0,0,0, "after_reset"));

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
